// File: rtl/msg512_unpack_if.sv
// Byte stream carrying the recovered message from msg512_unpack to its consumer.
// The master presents valid/address/data/last; the slave answers with out_ready.
interface msg512_unpack_if #(
    parameter int MSG_LENGTH = 55
) ();
    localparam int ADDR_WIDTH = $clog2(MSG_LENGTH);

    logic                  msg_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] msg_address;
    logic [7:0]            msg_data;
    logic                  msg_last;

    modport master (
        output msg_valid,
        output msg_address,
        output msg_data,
        output msg_last,
        input  out_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_address,
        input  msg_data,
        input  msg_last,
        output out_ready
    );
endinterface

// File: rtl/msg512_unpack.sv
// Validates SHA-256 padding of one 512-bit block and streams the original message
// back out one byte per valid/ready transfer, byte k taken from bits [511-8k -: 8].
module msg512_unpack #(
    parameter int MSG_LENGTH     = 55,
    parameter int MSG_BIT_LENGTH = MSG_LENGTH * 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [511:0]                     message_vector,
    output logic                             busy,
    output logic [$clog2(MSG_LENGTH+1)-1:0]  msg_byte_length,
    output logic                             done,
    output logic                             pad_error,
    msg512_unpack_if.master                  stream
);
    localparam int AW = $clog2(MSG_LENGTH);
    localparam int LW = $clog2(MSG_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STREAM,
        DONE
    } state_t;

    state_t          state_reg;
    logic [511:0]    block_reg;
    logic [AW-1:0]   addr_reg;
    logic [LW-1:0]   len_reg;
    logic [7:0]      data_reg;
    logic            valid_reg;
    logic            last_reg;
    logic            done_reg;
    logic            pad_error_reg;

    // Padding decode of the stored block, consumed only in CHECK.
    logic [63:0]     len_field;
    logic [LW-1:0]   l_val;
    logic [9:0]      marker_pos;
    logic            len_aligned;
    logic            len_in_range;
    logic [MSG_LENGTH:0] marker_hit;
    logic [446:0]    fill_bad;
    logic            pad_ok;

    assign len_field    = block_reg[63:0];
    assign l_val        = len_field[LW+2:3];
    assign marker_pos   = 10'd511 - {1'b0, l_val, 3'b000};
    assign len_aligned  = (len_field[2:0] == 3'b000);
    assign len_in_range = (len_field <= 64'(MSG_BIT_LENGTH));

    // The '1' marker sits at the MSB of byte L; only that one candidate is honoured.
    generate
        for (genvar gi = 0; gi <= MSG_LENGTH; gi++) begin : g_marker
            assign marker_hit[gi] = (l_val == LW'(gi)) && block_reg[511 - 8*gi];
        end
    endgenerate

    // Everything between the length field and the marker must be zero fill.
    generate
        for (genvar gi = 64; gi <= 510; gi++) begin : g_fill
            assign fill_bad[gi-64] = block_reg[gi] && (10'(gi) < marker_pos);
        end
    endgenerate

    assign pad_ok = len_aligned && len_in_range && (|marker_hit) && !(|fill_bad);

    logic [7:0] block_bytes [64];

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bytes
            assign block_bytes[gi] = block_reg[511 - 8*gi -: 8];
        end
    endgenerate

    logic [AW-1:0] addr_inc;
    assign addr_inc = addr_reg + AW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            block_reg     <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pad_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        block_reg     <= message_vector;
                        pad_error_reg <= 1'b0;
                        len_reg       <= '0;
                        state_reg     <= CHECK;
                    end
                end
                CHECK: begin
                    if (!pad_ok) begin
                        pad_error_reg <= 1'b1;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else if (l_val == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        len_reg   <= l_val;
                        addr_reg  <= '0;
                        data_reg  <= block_bytes[0];
                        last_reg  <= (l_val == LW'(1));
                        valid_reg <= 1'b1;
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    // Output registers only move on a transfer, so a stalled byte holds.
                    if (stream.out_ready) begin
                        if (last_reg) begin
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            addr_reg <= addr_inc;
                            data_reg <= block_bytes[addr_inc];
                            last_reg <= (LW'(addr_inc) == len_reg - LW'(1));
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy               = (state_reg != IDLE);
    assign msg_byte_length    = len_reg;
    assign done               = done_reg;
    assign pad_error          = pad_error_reg;
    assign stream.msg_valid   = valid_reg;
    assign stream.msg_address = addr_reg;
    assign stream.msg_data    = data_reg;
    assign stream.msg_last    = last_reg;
endmodule

// File: tb/tb_msg512_unpack.sv
// Directed bench for msg512_unpack: "abc", backpressure, empty and 55-byte
// messages, padding errors and reset mid-stream, all with hand-derived expectations.
module tb_msg512_unpack;
    logic         clk;
    logic         reset;
    logic         start;
    logic [511:0] message_vector;
    logic         busy;
    logic [5:0]   msg_byte_length;
    logic         done;
    logic         pad_error;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx [64];

    msg512_unpack_if #(.MSG_LENGTH(55)) sif ();

    msg512_unpack #(.MSG_LENGTH(55), .MSG_BIT_LENGTH(440)) dut (
        .clock           (clk),
        .reset           (reset),
        .start           (start),
        .message_vector  (message_vector),
        .busy            (busy),
        .msg_byte_length (msg_byte_length),
        .done            (done),
        .pad_error       (pad_error),
        .stream          (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] blk_byte(input logic [511:0] b, input int k);
        return b[511 - 8*k -: 8];
    endfunction

    // One request: start at edge t, cycle c is the c-th negedge after that edge.
    task automatic run_req(input string name, input logic [511:0] blk, input int exp_len,
                           input bit exp_err, input int stall_addr, input int stall_n);
        int  n;
        int  done_cyc;
        int  vseen;
        int  stalls;
        bit  fin;
        n = 0; done_cyc = -1; vseen = 0; stalls = stall_n; fin = 0;
        @(negedge clk);
        message_vector = blk;
        start = 1'b1;
        sif.out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 150 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                check_eq({name, "/busy_check"}, 64'(busy), 64'd1);
                check_eq({name, "/valid_check"}, 64'(sif.msg_valid), 64'd0);
            end
            if (sif.msg_valid) begin
                vseen++;
                check_eq({name, "/addr"}, 64'(sif.msg_address), 64'(n));
                check_eq({name, "/data"}, 64'(sif.msg_data), 64'(blk_byte(blk, n)));
                check_eq({name, "/last"}, 64'(sif.msg_last), 64'(n == exp_len - 1));
                check_eq({name, "/len"}, 64'(msg_byte_length), 64'(exp_len));
            end
            if (sif.msg_valid && n == stall_addr && stalls > 0) begin
                sif.out_ready = 1'b0;
                stalls--;
                start = 1'b1;
            end else begin
                sif.out_ready = 1'b1;
                if (sif.msg_valid) begin
                    rx[n] = sif.msg_data;
                    n++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1;
                check_eq({name, "/pad_error"}, 64'(pad_error), 64'(exp_err));
                if (!exp_err)
                    check_eq({name, "/len_done"}, 64'(msg_byte_length), 64'(exp_len));
            end
        end
        start = 1'b0;
        sif.out_ready = 1'b1;
        check_eq({name, "/done_cycle"}, 64'(done_cyc), 64'(exp_len + 2 + stall_n));
        check_eq({name, "/count"}, 64'(n), 64'(exp_len));
        if (exp_err || exp_len == 0)
            check_eq({name, "/no_valid"}, 64'(vseen), 64'd0);
        @(negedge clk);
        check_eq({name, "/done_pulse"}, 64'(done), 64'd0);
        check_eq({name, "/idle"}, 64'(busy), 64'd0);
        check_eq({name, "/pad_hold"}, 64'(pad_error), 64'(exp_err));
        $display("request %s: bytes=%0d done_cycle=%0d pad_error=%0b", name, n, done_cyc, pad_error);
    endtask

    logic [511:0] abc_blk;
    logic [511:0] b55;
    logic [511:0] blk;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        message_vector = '0;
        sif.out_ready = 1'b1;
        abc_blk = {32'h61626380, 416'd0, 64'h18};
        b55 = '0;
        for (int k = 0; k < 55; k++) b55[511 - 8*k -: 8] = 8'(k);
        b55[511 - 8*55 -: 8] = 8'h80;
        b55[63:0] = 64'h1B8;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst/busy", 64'(busy), 64'd0);
        check_eq("rst/valid", 64'(sif.msg_valid), 64'd0);
        check_eq("rst/addr", 64'(sif.msg_address), 64'd0);
        check_eq("rst/data", 64'(sif.msg_data), 64'd0);
        check_eq("rst/last", 64'(sif.msg_last), 64'd0);
        check_eq("rst/len", 64'(msg_byte_length), 64'd0);
        check_eq("rst/done", 64'(done), 64'd0);
        check_eq("rst/pad_error", 64'(pad_error), 64'd0);

        run_req("abc", abc_blk, 3, 1'b0, -1, 0);
        check_eq("abc/byte0", 64'(rx[0]), 64'h61);
        check_eq("abc/byte1", 64'(rx[1]), 64'h62);
        check_eq("abc/byte2", 64'(rx[2]), 64'h63);

        run_req("abc_stall", abc_blk, 3, 1'b0, 1, 3);
        check_eq("abc_stall/byte1", 64'(rx[1]), 64'h62);

        run_req("empty", {8'h80, 504'd0}, 0, 1'b0, -1, 0);

        run_req("len55", b55, 55, 1'b0, -1, 0);
        check_eq("len55/byte54", 64'(rx[54]), 64'h36);

        run_req("len_unaligned", {32'h61626380, 416'd0, 64'h19}, 0, 1'b1, -1, 0);
        run_req("len_too_big", {32'h61626380, 416'd0, 64'h1C0}, 0, 1'b1, -1, 0);
        run_req("no_marker", {32'h61626300, 416'd0, 64'h18}, 0, 1'b1, -1, 0);
        blk = abc_blk;
        blk[100] = 1'b1;
        run_req("fill_bit100", blk, 0, 1'b1, -1, 0);

        // Reset while address 1 of the 55-byte block is on the bus.
        @(negedge clk);
        message_vector = b55;
        start = 1'b1;
        sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (sif.msg_valid && sif.msg_address == 6'd1) seen = 1;
            end
            check_eq("rst_mid/reached_addr1", 64'(seen), 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_mid/busy", 64'(busy), 64'd0);
        check_eq("rst_mid/valid", 64'(sif.msg_valid), 64'd0);
        check_eq("rst_mid/addr", 64'(sif.msg_address), 64'd0);
        check_eq("rst_mid/data", 64'(sif.msg_data), 64'd0);
        check_eq("rst_mid/last", 64'(sif.msg_last), 64'd0);
        check_eq("rst_mid/len", 64'(msg_byte_length), 64'd0);
        check_eq("rst_mid/done", 64'(done), 64'd0);
        check_eq("rst_mid/pad_error", 64'(pad_error), 64'd0);
        begin
            int dones = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (done) dones++;
            end
            check_eq("rst_mid/no_done", 64'(dones), 64'd0);
        end
        $display("request reset_mid_stream: abandoned at address 1");

        run_req("abc_after_reset", abc_blk, 3, 1'b0, -1, 0);
        check_eq("abc_after_reset/byte2", 64'(rx[2]), 64'h63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
